alu_accumulator_unit: RTL and testbench

Parametrised accumulator/ALU datapath for the bus-based adder-accumulator design. Holds an accumulator A and an operand register B, both loaded from the shared bus, executes an opcode on an `exec` strobe and writes the result back into A with carry/zero/negative flags. Single-cycle ops complete in one clock; an optional shift-add multiplier runs as a multi-cycle operation under a busy/done handshake. The accumulator can be driven back onto the bus.

---
 rtl/alu_accumulator_unit.sv | 178 +++++++++++++++++
 tb/tb_alu_accumulator_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator_unit.sv
// Accumulator/ALU datapath: A and B loaded from the bus, 8 opcodes, registered C/Z/N flags.
// Optional multi-cycle shift-add multiplier on opcode 7, enabled by defining ALU_ACC_MUL_EN.
module alu_accumulator_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] bus_in_i,
    input  logic             load_a_i,
    input  logic             load_b_i,
    input  logic [2:0]       op_i,
    input  logic             exec_i,
    input  logic             out_en_i,
    output logic [WIDTH-1:0] bus_out_o,
    output logic             bus_oe_o,
    output logic [WIDTH-1:0] acc_o,
    output logic             cf_o,
    output logic             zf_o,
    output logic             nf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cf_q, cf_d, zf_q, zf_d, nf_q, nf_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             upd;
    logic             is_mul;
    logic             busy;

`ifdef ALU_ACC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd7;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     step_sum;

    assign busy   = (state_q == S_MUL);
    assign is_mul = (op_i == OP_MUL);
`else
    assign busy   = 1'b0;
    assign is_mul = 1'b0;
`endif

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        cf_d   = cf_q;
        zf_d   = zf_q;
        nf_d   = nf_q;
        done_d = 1'b0;
        res    = a_q;
        res_c  = 1'b0;
        upd    = 1'b0;
`ifdef ALU_ACC_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        step_sum = '0;
`endif
        if (!busy) begin
            if (exec_i) begin
                done_d = 1'b1;
                upd    = 1'b1;
                case (op_i)
                    OP_ADD: {res_c, res} = {1'b0, a_q} + {1'b0, b_q};
                    OP_SUB: {res_c, res} = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
                    OP_AND: res = a_q & b_q;
                    OP_OR:  res = a_q | b_q;
                    OP_XOR: res = a_q ^ b_q;
                    OP_SHL: {res_c, res} = {a_q, 1'b0};
                    OP_SHR: {res, res_c} = {1'b0, a_q};
                    default: begin
                        upd = 1'b0;
`ifdef ALU_ACC_MUL_EN
                        // Operands are snapshotted so A/B stay stable until write-back.
                        done_d  = 1'b0;
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH);
                        mcand_d = a_q;
                        prod_d  = {{WIDTH{1'b0}}, b_q};
`endif
                    end
                endcase
                if (upd) begin
                    a_d  = res;
                    cf_d = res_c;
                    zf_d = (res == '0);
                    nf_d = res[WIDTH-1];
                end
                // Op already consumed the old B; a MUL start needs B intact.
                if (load_b_i && !is_mul)
                    b_d = bus_in_i;
            end else begin
                if (load_a_i)
                    a_d = bus_in_i;
                if (load_b_i)
                    b_d = bus_in_i;
            end
        end
`ifdef ALU_ACC_MUL_EN
        else begin
            step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
            prod_d   = {step_sum, prod_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = S_IDLE;
                a_d     = prod_d[WIDTH-1:0];
                b_d     = prod_d[2*WIDTH-1:WIDTH];
                cf_d    = |prod_d[2*WIDTH-1:WIDTH];
                zf_d    = (prod_d[WIDTH-1:0] == '0);
                nf_d    = prod_d[WIDTH-1];
                done_d  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b0;
            nf_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            cf_q   <= cf_d;
            zf_q   <= zf_d;
            nf_q   <= nf_d;
            done_q <= done_d;
        end
    end

`ifdef ALU_ACC_MUL_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end
`endif

    assign bus_out_o = a_q;
    assign bus_oe_o  = out_en_i & ~busy;
    assign acc_o     = a_q;
    assign cf_o      = cf_q;
    assign zf_o      = zf_q;
    assign nf_o      = nf_q;
    assign busy_o    = busy;
    assign done_o    = done_q;

endmodule

// File: tb/tb_alu_accumulator_unit.sv
// Self-checking bench for alu_accumulator_unit (WIDTH=8): directed vector table, MUL/NOP
// corner sequences and a randomized run against an arithmetic reference model.
module tb_alu_accumulator_unit;

    localparam int W = 8;
    localparam int unsigned MASK = (1 << W) - 1;
`ifdef ALU_ACC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] bus;
    logic         load_a, load_b, exec, out_en;
    logic [2:0]   op;
    logic [W-1:0] bus_out, acc;
    logic         bus_oe, cf, zf, nf, busy, done;

    int checks   = 0;
    int failures = 0;

    alu_accumulator_unit #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus_in_i (bus),
        .load_a_i (load_a),
        .load_b_i (load_b),
        .op_i     (op),
        .exec_i   (exec),
        .out_en_i (out_en),
        .bus_out_o(bus_out),
        .bus_oe_o (bus_oe),
        .acc_o    (acc),
        .cf_o     (cf),
        .zf_o     (zf),
        .nf_o     (nf),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         la, lb;
        logic [W-1:0] bus;
        logic [2:0]   op;
        logic         ex, oe;
        logic [W-1:0] e_acc;
        logic         e_cf, e_zf, e_nf, e_done;
    } vec_t;
    vec_t vecs[$];

    // reference model state
    int unsigned ma, mb, pa, pb;
    bit          mcf, mzf, mnf, mdone;
    int          mrem;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        load_a = 1'b0; load_b = 1'b0; exec = 1'b0; op = 3'd0; bus = '0; out_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic la, input logic lb, input int unsigned b,
                         input logic [2:0] o, input logic ex);
        load_a = la; load_b = lb; bus = W'(b); op = o; exec = ex;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            clr_in();
            tick();
            n++;
        end
        if (busy !== 1'b0) check({name, "_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; pa = 0; pb = 0;
        mcf = 0; mzf = 0; mnf = 0; mdone = 0; mrem = 0;
    endtask

    task automatic model_edge();
        int unsigned     r;
        bit              c, wr;
        longint unsigned p;
        mdone = 0;
        if (mrem > 0) begin
            mrem--;
            if (mrem == 0) begin
                p     = longint'(pa) * longint'(pb);
                ma    = int'(p & MASK);
                mb    = int'((p >> W) & MASK);
                mcf   = (mb != 0);
                mzf   = (ma == 0);
                mnf   = ((ma >> (W - 1)) & 1) != 0;
                mdone = 1;
            end
        end else if (exec) begin
            wr = 1; mdone = 1; r = 0; c = 0;
            case (op)
                3'd0: begin r = (ma + mb) & MASK; c = (ma + mb) > MASK; end
                3'd1: begin r = (ma - mb) & MASK; c = (ma >= mb); end
                3'd2: r = ma & mb;
                3'd3: r = ma | mb;
                3'd4: r = ma ^ mb;
                3'd5: begin r = (ma << 1) & MASK; c = ((ma >> (W - 1)) & 1) != 0; end
                3'd6: begin r = ma >> 1; c = (ma & 1) != 0; end
                default: begin
                    wr = 0;
                    if (MUL_EN) begin
                        mdone = 0; mrem = W; pa = ma; pb = mb;
                    end
                end
            endcase
            if (wr) begin
                ma = r; mcf = c; mzf = (r == 0); mnf = ((r >> (W - 1)) & 1) != 0;
            end
            if (load_b && !(op == 3'd7 && MUL_EN)) mb = int'(bus);
        end else begin
            if (load_a) ma = int'(bus);
            if (load_b) mb = int'(bus);
        end
    endtask

    task automatic add_vec(input logic la, input logic lb, input int unsigned b, input logic [2:0] o,
                           input logic ex, input logic oe, input int unsigned ea,
                           input logic ec, input logic ez, input logic en, input logic ed);
        vec_t v;
        v.la = la; v.lb = lb; v.bus = W'(b); v.op = o; v.ex = ex; v.oe = oe;
        v.e_acc = W'(ea); v.e_cf = ec; v.e_zf = ez; v.e_nf = en; v.e_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        int bc, dc;
        // la lb bus op ex oe | acc cf zf nf done
        add_vec(1, 0, 200, 0, 0, 0, 200, 0, 0, 0, 0);
        add_vec(0, 1, 100, 0, 0, 1, 200, 0, 0, 0, 0);
        add_vec(0, 0,   0, 0, 1, 0,  44, 1, 0, 0, 1);
        add_vec(0, 0,   0, 0, 0, 1,  44, 1, 0, 0, 0);
        add_vec(1, 0,   5, 0, 0, 0,   5, 1, 0, 0, 0);
        add_vec(0, 1,   5, 0, 0, 0,   5, 1, 0, 0, 0);
        add_vec(0, 0,   0, 1, 1, 0,   0, 1, 1, 0, 1);
        add_vec(0, 1,   6, 0, 0, 0,   0, 1, 1, 0, 0);
        add_vec(0, 0,   0, 1, 1, 0, 250, 0, 0, 1, 1);
        add_vec(1, 0,'h11, 6, 1, 1, 125, 0, 0, 0, 1);
        add_vec(0, 0,   0, 5, 1, 0, 250, 0, 0, 1, 1);
        add_vec(0, 0,   0, 5, 1, 0, 244, 1, 0, 1, 1);
        add_vec(0, 1,'h0F, 4, 1, 0, 242, 0, 0, 1, 1);
        add_vec(0, 0,   0, 2, 1, 0,   2, 0, 0, 0, 1);
        add_vec(0, 0,   0, 3, 1, 1,  15, 0, 0, 0, 1);
        add_vec(1, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        add_vec(0, 0,   0, 2, 1, 0,   0, 0, 1, 0, 1);

        clr_in();
        rst = 1'b1;
        out_en = 1'b1;
        #12;
        check("rst_acc",  64'(acc), 64'(0));
        check("rst_flags", 64'({cf, zf, nf}), 64'(0));
        check("rst_busy_done", 64'({busy, done}), 64'(0));
        check("rst_bus_oe", 64'(bus_oe), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        clr_in();
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].la, vecs[i].lb, int'(vecs[i].bus), vecs[i].op, vecs[i].ex);
            out_en = vecs[i].oe;
            tick();
            check($sformatf("vec%0d_acc", i), 64'(acc), 64'(vecs[i].e_acc));
            check($sformatf("vec%0d_flags", i), 64'({cf, zf, nf}),
                  64'({vecs[i].e_cf, vecs[i].e_zf, vecs[i].e_nf}));
            check($sformatf("vec%0d_done_busy", i), 64'({done, busy}), 64'({vecs[i].e_done, 1'b0}));
            check($sformatf("vec%0d_bus", i), 64'({bus_oe, bus_out}), 64'({vecs[i].oe, vecs[i].e_acc}));
        end
        clr_in();

`ifdef ALU_ACC_MUL_EN
        drive(1, 1, 200, 0, 0); tick();
        drive(0, 1, 77, 7, 1); tick();      // load_b alongside MUL start is dropped
        bc = 0; dc = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) begin
                bc++;
                if (i == 0) check("mul_bus_oe_busy", 64'(bus_oe), 64'(0));
                drive(1, 1, 'h55, 3'(i % 7), 1);
                out_en = 1'b1;
            end else begin
                clr_in();
                out_en = 1'b1;
            end
            if (done === 1'b1) dc++;
            tick();
        end
        check("mul_busy_cycles", 64'(bc), 64'(8));
        check("mul_done_count", 64'(dc), 64'(1));
        check("mul_acc", 64'(acc), 64'('h40));
        check("mul_flags", 64'({cf, zf, nf}), 64'(3'b100));
        check("mul_bus_after", 64'({bus_oe, bus_out}), 64'({1'b1, 8'h40}));
        clr_in();
        drive(0, 0, 0, 1, 1); tick();       // 0x40 - B(0x9C)
        check("mul_b_hi_sub", 64'({acc, cf, nf}), 64'({8'd164, 1'b0, 1'b1}));
        clr_in();

        drive(1, 0, 15, 0, 0); tick();
        drive(0, 1, 17, 0, 0); tick();
        drive(0, 0, 0, 7, 1); tick();
        clr_in();
        wait_idle("mul2", 20);
        check("mul2_acc", 64'(acc), 64'(255));
        check("mul2_flags", 64'({cf, zf, nf}), 64'(3'b001));
        check("mul2_done", 64'(done), 64'(1));
        drive(0, 0, 0, 0, 1); tick();
        check("mul2_b_zero_add", 64'({acc, cf}), 64'({8'd255, 1'b0}));
        clr_in();

        drive(1, 1, 3, 0, 0); tick();
        drive(0, 0, 0, 7, 1); tick();
        clr_in();
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("mulrst_regs", 64'({acc, cf, zf, nf}), 64'(0));
        check("mulrst_busy_done", 64'({busy, done}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) dc++;
        end
        check("mulrst_no_done", 64'(dc), 64'(0));
        check("mulrst_acc_after", 64'({acc, busy}), 64'(0));
`else
        drive(1, 0, 7, 0, 0); tick();
        check("nop_pre_flags", 64'({cf, zf, nf}), 64'(3'b010));
        drive(0, 0, 0, 7, 1); tick();
        clr_in();
        check("nop_acc", 64'(acc), 64'(7));
        check("nop_flags", 64'({cf, zf, nf}), 64'(3'b010));
        check("nop_busy_done", 64'({busy, done}), 64'(2'b01));
        tick();
        check("nop_done_fall", 64'(done), 64'(0));
`endif

        clr_in();
        rst = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, MASK),
                  3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
            out_en = $urandom_range(0, 1) == 1;
            model_edge();
            tick();
            check("rnd_acc", 64'(acc), 64'(ma));
            check("rnd_flags", 64'({cf, zf, nf}), 64'({mcf, mzf, mnf}));
            check("rnd_busy_done", 64'({busy, done}), 64'({mrem > 0, mdone}));
            check("rnd_bus", 64'({bus_oe, bus_out}), 64'({out_en && !(mrem > 0), W'(ma)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
